// File: rtl/heap_arb_pkg.sv
// Shared encodings for the heap arbiter: FSM states and requester op codes.
package heap_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/heap_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after last+1, wrapping.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic found;

  // Walk the requesters starting just after the previous winner.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    any     = |req;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last) + k) % NREQ]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing one heap engine between NREQ requesters.
// Legality of the granted op is evaluated while granting so the engine strobe
// can be a registered output that is high exactly during the ISSUE cycle.
module heap_arbiter
  import heap_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 8,
  parameter int CAP     = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        op,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        ack,
  output logic                   err,
  output logic [DATA_W-1:0]      rdata,
  output logic                   busy,
  output logic                   heap_push,
  output logic                   heap_pop,
  output logic [DATA_W-1:0]      heap_din,
  input  logic [DATA_W-1:0]      heap_dout,
  input  logic [7:0]             heap_size,
  input  logic                   heap_done,
  input  logic                   heap_valid
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    last_r;
  logic                op_r;
  logic                legal_r;
  logic                err_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [IDX_W-1:0]    gnt_idx;
  logic                any;
  logic                win_op;
  logic                win_legal;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .last    (last_r),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Legality of the would-be winner, judged against the idle engine's current occupancy.
  always_comb begin
    win_op = op[gnt_idx];
    if (win_op == OP_POP) win_legal = (heap_size != 8'd0) && heap_valid;
    else                  win_legal = (32'(heap_size) < CAP);
  end

  // Arbitration FSM with registered engine strobes, busy flag and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_r    <= IDX_W'(NREQ - 1);
      idx_r     <= '0;
      op_r      <= OP_PUSH;
      legal_r   <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= '0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      heap_push <= 1'b0;
      heap_pop  <= 1'b0;
      heap_din  <= '0;
    end else begin
      heap_push <= 1'b0;
      heap_pop  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            idx_r     <= gnt_idx;
            op_r      <= win_op;
            legal_r   <= win_legal;
            heap_din  <= wdata[gnt_idx*DATA_W +: DATA_W];
            heap_push <= win_legal && (win_op == OP_PUSH);
            heap_pop  <= win_legal && (win_op == OP_POP);
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!legal_r) begin
            err_r   <= 1'b1;
            rdata_r <= '0;
            state   <= RESP;
          end else begin
            // Engine has not consumed the pop yet, so this is the pre-removal top.
            if (op_r == OP_POP) rdata_r <= heap_dout;
            cnt_r <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // Done takes precedence over a timeout landing in the same cycle.
          if (heap_done) begin
            if (op_r == OP_PUSH) rdata_r <= heap_dout;
            err_r <= 1'b0;
            state <= RESP;
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            err_r   <= 1'b1;
            rdata_r <= '0;
            state   <= RESP;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        RESP: begin
          last_r <= idx_r;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response outputs are decoded only from RESP and stable registers.
  always_comb begin
    ack   = '0;
    err   = 1'b0;
    rdata = '0;
    if (state == RESP) begin
      ack[idx_r] = 1'b1;
      err        = err_r;
      rdata      = rdata_r;
    end
  end

endmodule

// File: tb/tb_heap_arbiter.sv
// Self-checking bench for heap_arbiter with a behavioural max-heap engine and reference model.
module tb_heap_arbiter;

  localparam int NREQ    = 2;
  localparam int DATA_W  = 8;
  localparam int CAP     = 16;
  localparam int TIMEOUT = 255;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0]        op = '0;
  logic [NREQ*DATA_W-1:0] wdata = '0;
  logic [NREQ-1:0]        ack;
  logic                   err;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic                   heap_push;
  logic                   heap_pop;
  logic [DATA_W-1:0]      heap_din;
  logic [DATA_W-1:0]      heap_dout = '0;
  logic [7:0]             heap_size = '0;
  logic                   heap_done = 1'b0;
  logic                   heap_valid = 1'b0;

  heap_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .CAP(CAP), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .op         (op),
    .wdata      (wdata),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .busy       (busy),
    .heap_push  (heap_push),
    .heap_pop   (heap_pop),
    .heap_din   (heap_din),
    .heap_dout  (heap_dout),
    .heap_size  (heap_size),
    .heap_done  (heap_done),
    .heap_valid (heap_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] qmax(input logic [7:0] q[$]);
    logic [7:0] m = 8'd0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic int qmax_idx(input logic [7:0] q[$]);
    int k = 0;
    foreach (q[i]) if (q[i] > q[k]) k = i;
    return k;
  endfunction

  // ---------------- behavioural engine (max-heap) ----------------
  logic [7:0] eng_q[$];
  int         eng_d = 3;        // done latency; 0 = never completes; <0 = random 1..4
  int         eng_last_d = 0;
  int         eng_cnt = 0;
  logic       eng_op = 1'b0;
  logic [7:0] eng_key = '0;
  int         cmd_seq = 0;
  int         cmd_seen = 0;
  logic       cmd_clear = 1'b0;
  logic [7:0] cmd_key = '0;

  always @(posedge clk) begin
    #1;
    heap_done = 1'b0;
    if (!reset) begin
      eng_cnt = 0;
    end else begin
      if (cmd_seq != cmd_seen) begin
        cmd_seen = cmd_seq;
        if (cmd_clear) eng_q.delete();
        else           eng_q.push_back(cmd_key);
      end
      if (eng_cnt > 0) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) begin
          heap_done = 1'b1;
          if (eng_op) begin
            if (eng_q.size() > 0) eng_q.delete(qmax_idx(eng_q));
          end else begin
            eng_q.push_back(eng_key);
          end
        end
      end
      if (heap_push || heap_pop) begin
        eng_last_d = (eng_d < 0) ? int'($urandom_range(1, 4)) : eng_d;
        eng_op     = heap_pop;
        eng_key    = heap_din;
        eng_cnt    = eng_last_d;
      end
    end
    heap_size  = 8'(eng_q.size());
    heap_valid = (eng_q.size() > 0);
    heap_dout  = qmax(eng_q);
  end

  // ---------------- strobe monitor ----------------
  int         strobe_cnt = 0;
  int         both_cnt = 0;
  int         wide_cnt = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] din_seen = '0;

  always @(posedge clk) begin
    #1;
    if (heap_push && heap_pop) both_cnt = both_cnt + 1;
    if ((heap_push || heap_pop) && prev_strobe) wide_cnt = wide_cnt + 1;
    if (heap_push || heap_pop) begin
      strobe_cnt = strobe_cnt + 1;
      din_seen   = heap_din;
    end
    prev_strobe = heap_push || heap_pop;
  end

  // ---------------- reference model state ----------------
  logic [7:0] ref_q[$];
  int         ref_last = NREQ - 1;
  int         strobe_base = 0;
  int         batch_cnt[NREQ];
  logic       batch_op[NREQ];
  logic [7:0] batch_key[NREQ];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic backdoor_push(input logic [7:0] key);
    cmd_clear = 1'b0;
    cmd_key   = key;
    cmd_seq   = cmd_seq + 1;
    ref_q.push_back(key);
    tick();
  endtask

  task automatic backdoor_clear();
    cmd_clear = 1'b1;
    cmd_seq   = cmd_seq + 1;
    ref_q.delete();
    tick();
  endtask

  // Posts the batch requests and scores every ack against the reference model.
  task automatic run_batch(input bit chk_lat);
    int   rem[NREQ];
    int   left = 0;
    int   t0;
    int   budget = 0;
    bit   first = 1'b1;
    int   w;
    bit   legal;
    bit   tmo;
    logic [7:0] exp_rd;
    int   exp_lat;
    if (chk_lat) begin
      tick();
      tick();
    end
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = batch_cnt[i];
      left   = left + rem[i];
      op[i]  = batch_op[i];
      wdata[i*DATA_W +: DATA_W] = batch_key[i];
      req[i] = (rem[i] > 0);
    end
    t0 = cyc;
    strobe_base = strobe_cnt;
    while (left > 0 && budget < 2000) begin
      tick();
      budget = budget + 1;
      if (ack != '0) begin
        w = 0;
        for (int k = NREQ; k >= 1; k--)
          if (rem[(ref_last + k) % NREQ] > 0) w = (ref_last + k) % NREQ;
        legal = batch_op[w] ? (ref_q.size() > 0) : (ref_q.size() < CAP);
        tmo   = legal && (eng_last_d == 0);
        exp_rd = 8'd0;
        if (legal && !tmo) begin
          if (batch_op[w]) begin
            exp_rd = qmax(ref_q);
            ref_q.delete(qmax_idx(ref_q));
          end else begin
            ref_q.push_back(batch_key[w]);
            exp_rd = qmax(ref_q);
          end
        end
        chk("ack_onehot", 32'(ack), 32'(1 << w));
        chk("err", 32'(err), 32'(!legal || tmo));
        chk("rdata", 32'(rdata), 32'(exp_rd));
        chk("strobes", 32'(strobe_cnt - strobe_base), 32'(legal));
        if (legal && !batch_op[w]) chk("heap_din", 32'(din_seen), 32'(batch_key[w]));
        if (first && chk_lat) begin
          exp_lat = !legal ? 2 : (tmo ? 2 + TIMEOUT : 2 + eng_last_d);
          chk("latency", 32'(cyc - t0), 32'(exp_lat));
        end
        first       = 1'b0;
        ref_last    = w;
        rem[w]      = rem[w] - 1;
        left        = left - 1;
        if (rem[w] == 0) req[w] = 1'b0;
        strobe_base = strobe_cnt;
      end
    end
    if (left > 0) begin
      chk("batch_bound", 32'(left), 32'd0);
      req = '0;
    end
  endtask

  task automatic set_req(input int i, input int cnt, input logic o, input logic [7:0] key);
    batch_cnt[i] = cnt;
    batch_op[i]  = o;
    batch_key[i] = key;
  endtask

  task automatic clear_batch();
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int budget;
    clear_batch();
    // reset state
    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({heap_push, heap_pop}), 32'd0);
    chk("rst_din", 32'(heap_din), 32'd0);
    reset = 1'b1;
    tick();

    // pop on empty, requester 1
    eng_d = 3;
    clear_batch();
    set_req(1, 1, 1'b1, 8'h00);
    run_batch(1'b1);

    // single push 2A from requester 0, engine latency 3
    clear_batch();
    set_req(0, 1, 1'b0, 8'h2A);
    run_batch(1'b1);

    // full heap: push rejected, then pop returns the top
    for (int i = 0; i < CAP - 1; i++) backdoor_push(8'($urandom_range(0, 255)));
    clear_batch();
    set_req(0, 1, 1'b0, 8'h05);
    run_batch(1'b1);
    clear_batch();
    set_req(1, 1, 1'b1, 8'h00);
    run_batch(1'b1);

    // contention: both requesters push continuously, grants alternate
    backdoor_clear();
    eng_d = 1;
    clear_batch();
    set_req(0, 2, 1'b0, 8'h10);
    set_req(1, 2, 1'b0, 8'h20);
    run_batch(1'b1);

    // timeout on a pop, then a normal push
    eng_d = 0;
    clear_batch();
    set_req(0, 1, 1'b1, 8'h00);
    run_batch(1'b1);
    eng_d = 2;
    clear_batch();
    set_req(1, 1, 1'b0, 8'h33);
    run_batch(1'b1);

    // reset while waiting on the engine
    eng_d = 5;
    tick();
    op[1]  = 1'b1;
    req[1] = 1'b1;
    budget = 0;
    while (!heap_pop && budget < 10) begin
      tick();
      budget = budget + 1;
    end
    chk("rw_strobe_seen", 32'(heap_pop), 32'd1);
    tick();
    tick();
    #1 reset = 1'b0;
    #1;
    chk("rw_ack", 32'(ack), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_strobes", 32'({heap_push, heap_pop}), 32'd0);
    chk("rw_err_rdata", 32'({err, rdata}), 32'd0);
    req      = '0;
    ref_last = NREQ - 1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rw_busy_after", 32'(busy), 32'd0);
    eng_d = 1;
    clear_batch();
    set_req(0, 1, 1'b0, 8'h44);
    set_req(1, 1, 1'b0, 8'h55);
    run_batch(1'b1);

    // randomized batches
    eng_d = -1;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, int'($urandom_range(0, 3)),
                (b < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                8'($urandom_range(0, 255)));
      if (batch_cnt[0] == 0 && batch_cnt[1] == 0) batch_cnt[b % NREQ] = 1;
      run_batch(1'b0);
    end

    tick();
    chk("never_both_strobes", 32'(both_cnt), 32'd0);
    chk("strobe_single_cycle", 32'(wide_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/heap_arbiter.md
# heap_arbiter

Shares the single `heap` engine in the heap SoC between `NREQ` independent requesters, such as the KCPSM6 port block and hardware producers/consumers. Each requester posts a push or pop. The block grants requests round-robin and issues exactly one one-cycle `push`/`pop` strobe to the engine. It waits for `done`, then returns the result with a one-cycle acknowledge. It also rejects illegal operations (pop on empty, push on full) and stalled operations (timeout) without disturbing the engine.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `DATA_W`, 8: heap key width.
- `CAP`, 16: heap capacity; push is rejected when `heap_size == CAP`.
- `TIMEOUT`, 255: maximum number of cycles in WAIT before the operation is aborted.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `req` in NREQ: request per requester; held high until the requester's `ack` bit pulses.
- `op` in NREQ: per-requester operation, 0 = push, 1 = pop; held stable with `req`.
- `wdata` in NREQ*DATA_W: per-requester push key; slice i is bits [i*DATA_W +: DATA_W].
- `ack` out NREQ: one-cycle, one-hot completion pulse.
- `err` out 1: qualifies `ack`; 1 = rejected or timed out.
- `rdata` out DATA_W: result, valid while `ack` is nonzero.
- `busy` out 1: high in every state except IDLE.
- `heap_push`, `heap_pop` out 1: engine strobes; each is one cycle wide and never high in the same cycle as the other.
- `heap_din` out DATA_W: engine push key, registered.
- `heap_dout` in DATA_W: engine top-of-heap value.
- `heap_size` in 8: engine entry count.
- `heap_done` in 1: engine completion pulse.
- `heap_valid` in 1: engine `heap_dout` is meaningful (heap non-empty).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req` is high, select the winner with the round-robin picker, searching from `last+1` modulo NREQ.
  - Latch `idx`, `op[idx]` and the `wdata` slice into `heap_din`.
  - Go to ISSUE.
- ISSUE, legality check:
  - Illegal if the op is pop and `heap_size == 0` or `heap_valid == 0`.
  - Illegal if the op is push and `heap_size >= CAP`.
  - Illegal: set `err_r = 1`, `rdata_r = 0`, go to RESP. No strobe is issued.
- ISSUE, legal:
  - Drive `heap_push` or `heap_pop` for this single cycle.
  - For a pop, capture `rdata_r = heap_dout` (the top before removal).
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - On `heap_done`: for a push, `rdata_r = heap_dout` (the new top); `err_r = 0`; go to RESP.
  - When the counter reaches TIMEOUT: `err_r = 1`, `rdata_r = 0`, go to RESP.
  - A `heap_done` arriving in the same cycle as the timeout wins (success).
- RESP:
  - `ack[idx] = 1`; `err` and `rdata` are driven from `err_r` and `rdata_r`.
  - Set `last = idx`; return to IDLE.
- Round-robin: the winner is the first asserted `req` at or after `last+1`, wrapping. After reset `last = NREQ-1`, so requester 0 has first priority.
- If a requester drops `req` mid-transaction, the transaction still completes and `ack` still pulses. Requests are never cancelled.
- A requester re-asserting in the cycle after its `ack` is arbitrated normally. It will not win back-to-back while another request is pending.
- `heap_done` seen outside WAIT is ignored.

## Timing
- Reset values:
  - FSM = IDLE, `last = NREQ-1`.
  - `ack = 0`, `err = 0`, `rdata = 0`, `busy = 0`.
  - `heap_push = heap_pop = 0`, `heap_din = 0`.
- Latency from `req` rising (in IDLE) to `ack`, with engine done latency D ≥ 1 (done D cycles after the strobe):
  - Legal operation: 3 + D cycles, i.e. IDLE, ISSUE, WAIT×D, RESP.
  - Rejected operation: 3 cycles (IDLE, ISSUE, RESP).
  - Timeout: 3 + TIMEOUT cycles.
- Minimum spacing between two strobes is 4 cycles.
- Asserting reset mid-operation aborts immediately: no `ack` is issued and strobes go low asynchronously.
- All outputs are registered except `ack`, `err` and `rdata`. Those three are decoded from the RESP state and registered values, so they are glitch-free.

## Structure
- Package `heap_arb_pkg`: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3) and op encoding (OP_PUSH=0, OP_POP=1).
- Sub-module `rr_pick`:
  - Combinational NREQ-wide round-robin priority picker.
  - Inputs `req` and `last`; outputs `gnt_idx` and `any`.
  - Instantiated once.
- Timeout counter width is clog2(TIMEOUT+1).

## Test plan
- Single push: requester 0 pushes 8'h2A into an empty heap, engine D=3 -> exactly one `heap_push` with `heap_din = 2A`; `ack[0]` at cycle 6 with `err = 0`, `rdata = 2A`.
- Pop on empty: requester 1 pops with `heap_size = 0` -> no strobe; `ack[1]` at cycle 3 with `err = 1`, `rdata = 0`.
- Full: `heap_size = CAP = 16` and requester 0 pushes 8'h05 -> no strobe; `err = 1`. A subsequent pop returns the top and `err = 0`.
- Contention: both `req` held continuously, pushing 10 and 20 -> grants alternate 0, 1, 0, 1; each strobe is a single cycle; `heap_push` and `heap_pop` are never asserted together.
- Timeout: `heap_done` held low after a pop -> `ack` arrives 3 + 255 cycles after `req` with `err = 1`; the next request proceeds normally.
- Reset in WAIT: assert reset two cycles after the strobe -> all outputs are 0 within the same cycle; after release, `busy = 0` and requester 0 has priority.
